arp_server_subnet_top_hls_deadlock_report_unit: RTL and testbench
=================================================================

// Module: arp_server_subnet_top_hls_deadlock_report_unit
// PURPOSE
//  Central collector downstream of the per-process deadlock detect units. Watches every unit's
//  dl_detect_out, picks one origin process, broadcasts dl_detect_in, drives the origin/token pass,
//  records which processes the token visits, and publishes one deadlock-cycle report for debug.
//  One instance per dataflow region; the unit's outputs fan out to all detect units in that region.
// PARAMETERS
//  PROC_NUM      4    number of dataflow processes (detect units) monitored; >= 2
//  TRACE_TIMEOUT 64   max cycles in TRACE before the report is forced with timeout flag; >= 2
//  ID_W          derived localparam = max(1, clog2(PROC_NUM)); not overridable
// PORTS
//  clock           in   1         rising-edge clock
//  reset           in   1         asynchronous, active-low reset
//  dl_detect_vec   in   PROC_NUM  bit p = dl_detect_out of detect unit p
//  token_vec       in   PROC_NUM  bit p = OR of token_in_vec at detect unit p (token arrived)
//  report_ack      in   1         consumer accepts report; single-cycle pulse
//  dl_detect_out   out  1         broadcast to every unit's dl_detect_in
//  origin_vec      out  PROC_NUM  one-hot origin pulse, to each unit's origin input
//  token_clear     out  1         broadcast to every unit's token_clear
//  dl_report_vld   out  1         report valid, held until report_ack
//  dl_report_origin out ID_W      index of origin process
//  dl_report_chain out  PROC_NUM  bitmap of processes in the detected cycle
//  dl_report_len   out  ID_W+1    popcount of dl_report_chain
//  dl_report_tmo   out  1         trace ended by TRACE_TIMEOUT, not by token return
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, every output and internal register 0.
//  - FSM states IDLE, ORIGIN, TRACE, REPORT (2-bit encoding).
//  - IDLE: if |dl_detect_vec, origin_id <= lowest set index; dl_detect_out <= 1; -> ORIGIN.
//  - ORIGIN (1 cycle): origin_vec = 1<<origin_id this cycle only; chain <= 1<<origin_id; timer <= 0;
//    -> TRACE. Origin latched in IDLE is final even if other bits rise later.
//  - TRACE: each cycle chain <= chain | token_vec; timer++ (width clog2(TRACE_TIMEOUT)+1, no wrap).
//    * token_vec[origin_id]=1: token_clear pulses 1 cycle (next cycle), tmo<=0, -> REPORT.
//    * else timer==TRACE_TIMEOUT-1: tmo<=1, token_clear pulses, -> REPORT.
//    * dl_detect_vec==0 for 2 consecutive cycles (false positive resolved) with no token return:
//      abort -> IDLE, dl_detect_out<=0, token_clear pulses, no report.
//    * Priority when coincident: token return > timeout > abort.
//  - REPORT: dl_report_vld=1; origin/chain/len/tmo stable; len = popcount(chain) registered on
//    entry. dl_detect_out stays 1 (units stay frozen). On report_ack -> IDLE, dl_report_vld<=0,
//    dl_detect_out<=0; report fields hold last values until next REPORT entry.
//  - report_ack outside REPORT is ignored. token_vec outside TRACE is ignored.
//  - Latency: dl_detect_vec rise -> dl_detect_out=1 and state ORIGIN after 1 edge; origin_vec after
//    2 edges; min detect-to-report = 4 edges (2-proc cycle with immediate token return).
//  - Reset asserted mid-operation: immediate return to reset values; no partial report emitted.
//  - Re-detection after IDLE re-entry restarts from scratch (chain cleared in ORIGIN).
// STRUCTURE
//  - Shared package/include: FSM state constants, ID_W/clog2 function, report field widths.
//  - One sub-module: arp_server_subnet_top_hls_deadlock_prio_enc (PROC_NUM-bit lowest-index
//    priority encoder -> ID_W index + valid); popcount stays inline.
// TESTING (PROC_NUM=4, TRACE_TIMEOUT=8)
//  - Reset: all outputs 0 while reset=0; release with dl_detect_vec=0 -> outputs stay 0, IDLE.
//  - dl_detect_vec=4'b0110 -> origin_id=1, origin_vec=4'b0010 1 cycle; token_vec 4'b0100 then
//    4'b0010 -> token_clear 1 pulse, report origin=1 chain=4'b0110 len=2 tmo=0.
//  - dl_detect_vec=4'b1000, token_vec never returns -> after 8 TRACE cycles tmo=1, chain=4'b1000,
//    len=1, token_clear pulses once.
//  - In TRACE drop dl_detect_vec to 0 for 2 cycles -> IDLE, dl_detect_out=0, dl_report_vld stays 0.
//  - Token return and timeout on same cycle -> tmo=0 (token wins); report_ack -> IDLE next edge,
//    then new dl_detect_vec=4'b0001 yields fresh report chain starting 4'b0001.
//  - Assert reset during TRACE -> all outputs 0 asynchronously; no report after release.

Source files
------------

// File: rtl/arp_server_subnet_top_hls_deadlock_report_unit_pkg.sv
// Shared definitions for the dataflow deadlock report unit: FSM encoding and width helpers.
package arp_server_subnet_top_hls_deadlock_report_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ORIGIN = 2'd1,
    ST_TRACE  = 2'd2,
    ST_REPORT = 2'd3
  } dl_state_e;

  // Process index width; a 2-process region still needs one bit.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Trace timer width; one spare bit so the terminal count never wraps.
  function automatic int timer_width(input int t);
    return $clog2(t) + 1;
  endfunction

endpackage

// File: rtl/arp_server_subnet_top_hls_deadlock_prio_enc.sv
// Lowest-index priority encoder: picks the deadlock origin among all asserting detect units.
module arp_server_subnet_top_hls_deadlock_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         vld
);

  // Scan high-to-low so the lowest set bit is the last writer.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arp_server_subnet_top_hls_deadlock_report_unit.sv
// Deadlock report collector: selects an origin, runs the token trace and publishes one cycle report.
module arp_server_subnet_top_hls_deadlock_report_unit
  import arp_server_subnet_top_hls_deadlock_report_unit_pkg::*;
#(
  parameter  int PROC_NUM      = 4,
  parameter  int TRACE_TIMEOUT = 64,
  localparam int ID_W          = id_width(PROC_NUM)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_vec,
  input  logic                report_ack,
  output logic                dl_detect_out,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                dl_report_vld,
  output logic [ID_W-1:0]     dl_report_origin,
  output logic [PROC_NUM-1:0] dl_report_chain,
  output logic [ID_W:0]       dl_report_len,
  output logic                dl_report_tmo
);

  localparam int TW = timer_width(TRACE_TIMEOUT);

  dl_state_e           state, state_d;
  logic [ID_W-1:0]     origin_id, enc_idx;
  logic                enc_vld;
  logic [PROC_NUM-1:0] chain, chain_nxt, origin_oh;
  logic [TW-1:0]       timer;
  logic                quiet;
  logic                tok_ret, tmo_hit, quiet_now, abort;
  logic [ID_W:0]       pop;

  arp_server_subnet_top_hls_deadlock_prio_enc #(
    .N (PROC_NUM),
    .W (ID_W)
  ) u_prio_enc (
    .req (dl_detect_vec),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  always_comb begin
    origin_oh            = '0;
    origin_oh[origin_id] = 1'b1;
    chain_nxt            = chain | token_vec;
    tok_ret              = token_vec[origin_id];
    tmo_hit              = (timer == TW'(TRACE_TIMEOUT - 1));
    quiet_now            = (dl_detect_vec == '0);
    // Second consecutive quiet cycle: the detection was a transient false positive.
    abort                = quiet && quiet_now;
    pop                  = '0;
    for (int i = 0; i < PROC_NUM; i++) pop = pop + {{ID_W{1'b0}}, chain_nxt[i]};
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (enc_vld) state_d = ST_ORIGIN;
      ST_ORIGIN: state_d = ST_TRACE;
      ST_TRACE: begin
        if (tok_ret || tmo_hit) state_d = ST_REPORT;
        else if (abort)         state_d = ST_IDLE;
      end
      ST_REPORT: if (report_ack) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      origin_id        <= '0;
      chain            <= '0;
      timer            <= '0;
      quiet            <= 1'b0;
      dl_detect_out    <= 1'b0;
      origin_vec       <= '0;
      token_clear      <= 1'b0;
      dl_report_vld    <= 1'b0;
      dl_report_origin <= '0;
      dl_report_chain  <= '0;
      dl_report_len    <= '0;
      dl_report_tmo    <= 1'b0;
    end else begin
      origin_vec  <= '0;
      token_clear <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enc_vld) begin
            origin_id     <= enc_idx;
            dl_detect_out <= 1'b1;
          end
        end
        ST_ORIGIN: begin
          origin_vec <= origin_oh;
          chain      <= origin_oh;
          timer      <= '0;
          quiet      <= 1'b0;
        end
        ST_TRACE: begin
          chain <= chain_nxt;
          quiet <= quiet_now;
          if (timer != '1) timer <= timer + TW'(1);
          if (tok_ret || tmo_hit) begin
            // Token return outranks timeout when both land on the same cycle.
            token_clear      <= 1'b1;
            dl_report_vld    <= 1'b1;
            dl_report_origin <= origin_id;
            dl_report_chain  <= chain_nxt;
            dl_report_len    <= pop;
            dl_report_tmo    <= !tok_ret;
          end else if (abort) begin
            token_clear   <= 1'b1;
            dl_detect_out <= 1'b0;
          end
        end
        ST_REPORT: begin
          if (report_ack) begin
            dl_report_vld <= 1'b0;
            dl_detect_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_server_subnet_top_hls_deadlock_report_unit.sv
// Bench for the deadlock report unit: vector table of trace scenarios plus hand-built corner sequences.
module tb_arp_server_subnet_top_hls_deadlock_report_unit;

  localparam int P  = 4;
  localparam int T  = 8;
  localparam int IW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [P-1:0]  dl_detect_vec = '0;
  logic [P-1:0]  token_vec = '0;
  logic          report_ack = 1'b0;
  logic          dl_detect_out;
  logic [P-1:0]  origin_vec;
  logic          token_clear;
  logic          dl_report_vld;
  logic [IW-1:0] dl_report_origin;
  logic [P-1:0]  dl_report_chain;
  logic [IW:0]   dl_report_len;
  logic          dl_report_tmo;

  always #5 clock = ~clock;

  arp_server_subnet_top_hls_deadlock_report_unit #(
    .PROC_NUM      (P),
    .TRACE_TIMEOUT (T)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .dl_detect_vec    (dl_detect_vec),
    .token_vec        (token_vec),
    .report_ack       (report_ack),
    .dl_detect_out    (dl_detect_out),
    .origin_vec       (origin_vec),
    .token_clear      (token_clear),
    .dl_report_vld    (dl_report_vld),
    .dl_report_origin (dl_report_origin),
    .dl_report_chain  (dl_report_chain),
    .dl_report_len    (dl_report_len),
    .dl_report_tmo    (dl_report_tmo)
  );

  typedef struct {
    logic [3:0] det;
    logic [3:0] tok_a;
    logic [3:0] tok_b;
    logic [1:0] origin;
    logic [3:0] chain;
    logic [2:0] len;
    logic       tmo;
    int         lat;
  } vec_t;

  typedef struct {
    logic [1:0] origin;
    logic [3:0] chain;
    logic [2:0] len;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] o, input logic [3:0] c, input logic [2:0] l, input logic t);
    exp_t x;
    x.origin = o; x.chain = c; x.len = l; x.tmo = t;
    sb.push_back(x);
  endtask

  task automatic check_report();
    exp_t x;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_underflow actual=report required=none");
    end else begin
      x = sb.pop_front();
      chk("rpt_origin", dl_report_origin, x.origin);
      chk("rpt_chain",  dl_report_chain,  x.chain);
      chk("rpt_len",    dl_report_len,    x.len);
      chk("rpt_tmo",    dl_report_tmo,    x.tmo);
    end
  endtask

  task automatic ack_report(input logic [3:0] chain_exp);
    token_vec = '0; dl_detect_vec = '0;
    @(negedge clock);
    chk("clear_pulse_end", token_clear, 0);
    chk("vld_held", dl_report_vld, 1);
    chk("detect_held", dl_detect_out, 1);
    report_ack = 1'b1;
    @(negedge clock);
    report_ack = 1'b0;
    chk("ack_vld", dl_report_vld, 0);
    chk("ack_detect", dl_detect_out, 0);
    chk("chain_hold", dl_report_chain, chain_exp);
  endtask

  task automatic run_vec(input vec_t v);
    int  tc;
    bit  seen;
    tc = 0; seen = 0;
    push_exp(v.origin, v.chain, v.len, v.tmo);
    dl_detect_vec = v.det; token_vec = '0;
    for (int e = 1; e <= 30 && !seen; e++) begin
      @(negedge clock);
      if (token_clear) tc++;
      if (e == 1) begin
        chk("detect_rise", dl_detect_out, 1);
        chk("origin_vec_early", origin_vec, 0);
      end
      if (e == 2) chk("origin_vec", origin_vec, 4'b0001 << v.origin);
      if (e == 3) chk("origin_vec_pulse", origin_vec, 0);
      if (dl_report_vld) begin
        seen = 1;
        chk("latency", e, v.lat);
        check_report();
      end else begin
        token_vec = (e == 2) ? v.tok_a : (e == 3) ? v.tok_b : 4'b0000;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL report_wait actual=none required=report");
    end
    chk("token_clear_once", tc, 1);
    ack_report(v.chain);
  endtask

  initial begin
    int hits;
    tbl[0] = '{4'b0110, 4'b0100, 4'b0010, 2'd1, 4'b0110, 3'd2, 1'b0, 4};
    tbl[1] = '{4'b1000, 4'b0000, 4'b0000, 2'd3, 4'b1000, 3'd1, 1'b1, 10};
    tbl[2] = '{4'b1010, 4'b0100, 4'b0011, 2'd1, 4'b0111, 3'd3, 1'b0, 4};
    tbl[3] = '{4'b1111, 4'b1110, 4'b0001, 2'd0, 4'b1111, 3'd4, 1'b0, 4};
    tbl[4] = '{4'b0010, 4'b0100, 4'b1000, 2'd1, 4'b1110, 3'd3, 1'b1, 10};
    tbl[5] = '{4'b0100, 4'b1000, 4'b0100, 2'd2, 4'b1100, 3'd2, 1'b0, 4};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_detect", dl_detect_out, 0);
    chk("rst_origin_vec", origin_vec, 0);
    chk("rst_clear", token_clear, 0);
    chk("rst_vld", dl_report_vld, 0);
    chk("rst_fields", {dl_report_origin, dl_report_chain, dl_report_len, dl_report_tmo}, 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_detect", dl_detect_out, 0);
    chk("idle_vld", dl_report_vld, 0);
    chk("idle_origin_vec", origin_vec, 0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Abort: detection disappears for two cycles during the trace
    dl_detect_vec = 4'b0010;
    repeat (2) @(negedge clock);
    dl_detect_vec = '0;
    @(negedge clock);
    chk("abort_not_early", dl_detect_out, 1);
    chk("abort_clear_early", token_clear, 0);
    @(negedge clock);
    chk("abort_detect", dl_detect_out, 0);
    chk("abort_clear", token_clear, 1);
    chk("abort_vld", dl_report_vld, 0);
    @(negedge clock);
    chk("abort_clear_pulse", token_clear, 0);
    hits = 0;
    repeat (5) begin
      @(negedge clock);
      if (dl_report_vld) hits++;
    end
    chk("abort_no_report", hits, 0);

    // Token return lands on the timeout cycle: token wins
    push_exp(2'd3, 4'b1000, 3'd1, 1'b0);
    dl_detect_vec = 4'b1000;
    repeat (9) @(negedge clock);
    chk("tmo_not_early", dl_report_vld, 0);
    token_vec = 4'b1000;
    @(negedge clock);
    chk("coinc_vld", dl_report_vld, 1);
    chk("coinc_clear", token_clear, 1);
    check_report();
    ack_report(4'b1000);
    run_vec('{4'b0001, 4'b0010, 4'b0001, 2'd0, 4'b0011, 3'd2, 1'b0, 4});

    // Reset asserted mid-trace
    dl_detect_vec = 4'b0110;
    repeat (3) @(negedge clock);
    token_vec = 4'b0100;
    reset = 1'b0;
    #1;
    chk("mid_rst_detect", dl_detect_out, 0);
    chk("mid_rst_origin_vec", origin_vec, 0);
    chk("mid_rst_clear", token_clear, 0);
    chk("mid_rst_vld", dl_report_vld, 0);
    chk("mid_rst_fields", {dl_report_origin, dl_report_chain, dl_report_len, dl_report_tmo}, 0);
    dl_detect_vec = '0; token_vec = '0;
    @(negedge clock);
    reset = 1'b1;
    hits = 0;
    repeat (12) begin
      @(negedge clock);
      if (dl_report_vld || dl_detect_out) hits++;
    end
    chk("post_rst_quiet", hits, 0);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
